alu_pipe_hs: RTL and testbench

//  Parametrised successor of the generated pipelined ALUs, with a valid/ready handshake on both sides.

---
 rtl/alu_pipe_hs.sv | 167 ++++++++++++++++
 tb/tb_alu_pipe_hs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_hs.sv
// Pipelined ALU with valid/ready handshake on issue and writeback sides; iterative shift-add MUL.
// Define ALU_SRA_EN to make opcode 5 an arithmetic right shift (otherwise it is an illegal opcode).
module alu_pipe_hs #(
    parameter  int WIDTH   = 128,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry_flag,
    output logic               zero_flag,
    output logic               sign_flag,
    output logic               ovf_flag,
    output logic               err_flag
);
    // state | meaning
    // IDLE  | no result held, waiting for an operation
    // EXEC  | single-cycle op latched, result registered this cycle
    // MUL   | shift-add iterations, cnt counts down to terminal zero
    // DONE  | result held until consumed; may accept a new op on consume
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
`ifdef ALU_SRA_EN
    localparam logic [2:0] OP_SRA = 3'd5;
`endif
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [SHIFT_W-1:0] sh_q;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic             accept;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] ex_result;
    logic             ex_carry;
    logic             ex_ovf;
    logic             ex_err;
    logic [WIDTH:0]   mul_sum;

    assign in_ready = !rst && (state == IDLE || state == DONE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // The extra bit of 'wide' carries the carry/borrow or the last bit shifted out.
    always_comb begin
        wide      = '0;
        ex_result = '0;
        ex_carry  = 1'b0;
        ex_ovf    = 1'b0;
        ex_err    = 1'b0;
        case (op_q)
            OP_ADD: begin
                wide      = {1'b0, a_q} + {1'b0, b_q};
                ex_result = wide[WIDTH-1:0];
                ex_carry  = wide[WIDTH];
                ex_ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ex_result[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                wide      = {1'b0, a_q} - {1'b0, b_q};
                ex_result = wide[WIDTH-1:0];
                ex_carry  = wide[WIDTH];
                ex_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ex_result[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SRL: begin
                wide      = {a_q, 1'b0} >> sh_q;
                ex_result = wide[WIDTH:1];
                ex_carry  = wide[0];
            end
            OP_SLL: begin
                wide      = {1'b0, a_q} << sh_q;
                ex_result = wide[WIDTH-1:0];
                ex_carry  = wide[WIDTH];
            end
`ifdef ALU_SRA_EN
            OP_SRA: begin
                wide      = $unsigned($signed({a_q, 1'b0}) >>> sh_q);
                ex_result = wide[WIDTH:1];
                ex_carry  = wide[0];
            end
`endif
            default: ex_err = 1'b1;
        endcase
    end

    // Multiplier B lives in the low half of acc and is consumed LSB-first.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sh_q       <= '0;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            sign_flag  <= 1'b0;
            ovf_flag   <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    if (accept) begin
                        a_q   <= input1;
                        b_q   <= input2;
                        op_q  <= opcode;
                        sh_q  <= shift_amt;
                        acc   <= {{WIDTH{1'b0}}, input2};
                        cnt   <= CNT_W'(WIDTH);
                        state <= (opcode == OP_MUL) ? MUL : EXEC;
                    end else if (!out_valid || out_ready) begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    result     <= ex_result;
                    carry_flag <= ex_carry;
                    zero_flag  <= (ex_result == '0);
                    sign_flag  <= ex_result[WIDTH-1];
                    ovf_flag   <= ex_ovf;
                    err_flag   <= ex_err;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                MUL: begin
                    if (cnt != '0) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt - 1'b1;
                    end else begin
                        result     <= acc[WIDTH-1:0];
                        carry_flag <= |acc[2*WIDTH-1:WIDTH];
                        zero_flag  <= (acc[WIDTH-1:0] == '0);
                        sign_flag  <= acc[WIDTH-1];
                        ovf_flag   <= 1'b0;
                        err_flag   <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs: vector table through a scoreboard plus latency, backpressure and reset sequences.
module tb_alu_pipe_hs;
    localparam int W = 128;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     opcode = '0;
    logic [W-1:0]   input1 = '0;
    logic [W-1:0]   input2 = '0;
    logic [6:0]     shift_amt = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   result;
    logic           carry_flag, zero_flag, sign_flag, ovf_flag, err_flag;

    alu_pipe_hs #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .input1(input1), .input2(input2), .shift_amt(shift_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .sign_flag(sign_flag), .ovf_flag(ovf_flag), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    // flags packed as {carry, zero, sign, ovf, err}
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [6:0]   sh;
        logic [W-1:0] r;
        logic [4:0]   f;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] r;
        logic [4:0]   f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got result %h with no operation outstanding", result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.r);
                chk("flags", {123'd0, carry_flag, zero_flag, sign_flag, ovf_flag, err_flag}, {123'd0, mon_e.f});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [6:0] sh, input logic [W-1:0] er, input logic [4:0] ef,
                         output int acc_cyc);
        bit done = 0;
        in_valid  = 1'b1;
        opcode    = op;
        input1    = a;
        input2    = b;
        shift_amt = sh;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{er, ef});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance required in_ready within 400 cycles");
        end
    endtask

    task automatic wait_valid(output int n, output bit ready_seen);
        n = 0;
        ready_seen = 0;
        while (!out_valid && n < 300) begin
            if (in_ready) ready_seen = 1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    localparam logic [W-1:0] ALL1   = {W{1'b1}};
    localparam logic [W-1:0] MSB    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] SMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG2   = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0] MSBLSB = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [W-1:0] P64    = {{(W-65){1'b0}}, 1'b1, 64'd0};
    localparam logic [W-1:0] SRA5   = {5'b11111, {(W-5){1'b0}}};

    vec_t tv[16];

    initial begin
        int  ca, cb, n;
        bit  rs, bad;

        tv[0]  = '{3'd0, ALL1,     128'd1, 7'd0,   128'd0,  5'b11000};
        tv[1]  = '{3'd1, 128'd5,   128'd7, 7'd0,   NEG2,    5'b10100};
        tv[2]  = '{3'd1, SMAX,     ALL1,   7'd0,   MSB,     5'b10110};
        tv[3]  = '{3'd0, 128'd3,   128'd4, 7'd0,   128'd7,  5'b00000};
        tv[4]  = '{3'd4, MSBLSB,   128'd0, 7'd1,   128'd2,  5'b10000};
        tv[5]  = '{3'd3, MSBLSB,   128'd0, 7'd0,   MSBLSB,  5'b00100};
        tv[6]  = '{3'd2, P64,      P64,    7'd0,   128'd0,  5'b11000};
        tv[7]  = '{3'd2, 128'd3,   128'd5, 7'd0,   128'd15, 5'b00000};
        tv[8]  = '{3'd6, 128'd9,   128'd9, 7'd3,   128'd0,  5'b01001};
`ifdef ALU_SRA_EN
        tv[9]  = '{3'd5, MSB,      128'd0, 7'd4,   SRA5,    5'b00100};
`else
        tv[9]  = '{3'd5, MSB,      128'd0, 7'd4,   128'd0,  5'b01001};
`endif
        tv[10] = '{3'd3, 128'h13,  128'd0, 7'd1,   128'd9,  5'b10000};
        tv[11] = '{3'd0, SMAX,     128'd1, 7'd0,   MSB,     5'b00110};
        tv[12] = '{3'd2, ALL1,     ALL1,   7'd0,   128'd1,  5'b10000};
        tv[13] = '{3'd4, 128'd1,   128'd0, 7'd127, MSB,     5'b00100};
        tv[14] = '{3'd7, ALL1,     ALL1,   7'd5,   128'd0,  5'b01001};
        tv[15] = '{3'd1, 128'd9,   128'd9, 7'd0,   128'd0,  5'b01000};

        // reset state
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // ADD latency: result visible one edge after the accepting edge
        issue(3'd0, ALL1, 128'd1, 7'd0, 128'd0, 5'b11000, ca);
        wait_valid(n, rs);
        chk("add_latency", n, 1);
        @(posedge clk);
        #1;

        // MUL latency and in_ready held low throughout
        issue(3'd2, P64, P64, 7'd0, 128'd0, 5'b11000, ca);
        wait_valid(n, rs);
        chk("mul_latency", n, 129);
        chk("mul_in_ready_low", rs, 0);
        @(posedge clk);
        #1;

        // back-to-back single-cycle ops: one accept every two cycles
        issue(3'd0, 128'd1, 128'd1, 7'd0, 128'd2, 5'b00000, ca);
        issue(3'd0, 128'd2, 128'd2, 7'd0, 128'd4, 5'b00000, cb);
        chk("throughput", cb - ca, 2);
        repeat (3) @(posedge clk);
        #1;

        // backpressure with the next op pending
        out_ready = 1'b0;
        issue(3'd0, 128'd3, 128'd4, 7'd0, 128'd7, 5'b00000, ca);
        wait_valid(n, rs);
        in_valid = 1'b1; opcode = 3'd1; input1 = 128'd10; input2 = 128'd3; shift_amt = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_result", result, 7);
            chk("held_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_on_consume", in_ready, 1);
        sb.push_back('{128'd7, 5'b00000});
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("valid_dropped", out_valid, 0);
        wait_valid(n, rs);
        chk("pending_latency", n, 1);
        @(posedge clk);
        #1;

        // in_valid offered while busy then withdrawn: must leave no trace
        issue(3'd2, 128'd3, 128'd5, 7'd0, 128'd15, 5'b00000, ca);
        in_valid = 1'b1; opcode = 3'd0; input1 = 128'd1; input2 = 128'd1;
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(n, rs);
        repeat (5) @(posedge clk);
        #1;

        // reset at MUL iteration 40 discards the operation
        issue(3'd2, ALL1, ALL1, 7'd0, 128'd1, 5'b10000, ca);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        sb.delete();
        chk("midmul_rst_out_valid", out_valid, 0);
        chk("midmul_rst_result", result, 0);
        chk("midmul_rst_flags", {carry_flag, zero_flag, sign_flag, ovf_flag, err_flag}, 0);
        chk("midmul_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        chk("no_output_after_rst", bad, 0);
        @(posedge clk);
        #1;

        // vector table
        for (int i = 0; i < 16; i++)
            issue(tv[i].op, tv[i].a, tv[i].b, tv[i].sh, tv[i].r, tv[i].f, ca);

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
